// File: rtl/nibble_reduce_seq.sv
// Nibble-serial AND/OR/XOR reduction sequencer: accepts a WIDTH-bit word, feeds one
// nibble per cycle through a gates4 unit and returns the full-word reductions.

module gates4 (
  input  logic [3:0] i_nib,
  output logic       o_and,
  output logic       o_or,
  output logic       o_xor
);
  assign o_and = &i_nib;
  assign o_or  = |i_nib;
  assign o_xor = ^i_nib;
endmodule

module nibble_reduce_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic             busy
);
  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_acc_and;
  logic               r_acc_or;
  logic               r_acc_xor;
  logic               r_out_and;
  logic               r_out_or;
  logic               r_out_xor;
  logic               r_out_valid;
  logic               w_g_and;
  logic               w_g_or;
  logic               w_g_xor;
  logic               w_acc_and;
  logic               w_acc_or;
  logic               w_acc_xor;
  logic               w_last;
  logic               w_accept;

  gates4 u_gates4 (
    .i_nib (r_shreg[3:0]),
    .o_and (w_g_and),
    .o_or  (w_g_or),
    .o_xor (w_g_xor)
  );

  assign w_acc_and = r_acc_and & w_g_and;
  assign w_acc_or  = r_acc_or  | w_g_or;
  assign w_acc_xor = r_acc_xor ^ w_g_xor;
  assign w_last    = (r_cnt == CNT_W'(NIB - 1));
  assign w_accept  = in_valid && (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: load on accept, fold one nibble per RUN cycle, publish on the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_acc_and   <= 1'b0;
      r_acc_or    <= 1'b0;
      r_acc_xor   <= 1'b0;
      r_out_and   <= 1'b0;
      r_out_or    <= 1'b0;
      r_out_xor   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shreg   <= in_data;
        r_cnt     <= '0;
        r_acc_and <= 1'b1;
        r_acc_or  <= 1'b0;
        r_acc_xor <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_shreg   <= r_shreg >> 4;
        r_cnt     <= r_cnt + CNT_W'(1);
        r_acc_and <= w_acc_and;
        r_acc_or  <= w_acc_or;
        r_acc_xor <= w_acc_xor;
        if (w_last) begin
          r_out_and   <= w_acc_and;
          r_out_or    <= w_acc_or;
          r_out_xor   <= w_acc_xor;
          r_out_valid <= 1'b1;
        end
      end else if ((r_state == S_DONE) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign out_valid = r_out_valid;
  assign out_and   = r_out_and;
  assign out_or    = r_out_or;
  assign out_xor   = r_out_xor;

endmodule
